// File: rtl/vga2_fb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vga2_fb_arbiter_pkg
// Shared VGA2 framebuffer definitions: the pixel color width, the default
// screen geometry and the linear framebuffer address computation. These are
// used by both the arbiter and its write queue.
// ---------------------------------------------------------------------------
package vga2_fb_arbiter_pkg;

    // Pixel color is {r,g,b}, one bit each.
    localparam int unsigned COLOR_W = 3;

    // Default geometry (640x480 visible area, 11-bit coordinates).
    localparam int unsigned DEF_H_ADDR_SIZE   = 11;
    localparam int unsigned DEF_V_ADDR_SIZE   = 11;
    localparam int unsigned DEF_H_VISIBLE     = 640;
    localparam int unsigned DEF_V_VISIBLE     = 480;
    localparam int unsigned DEF_RAM_ADDR_SIZE = 19;

    // Row-major linear address: v * h_visible + h. The caller truncates the
    // result to its RAM address width.
    function automatic logic [31:0] fb_addr(
        input logic [31:0] h,
        input logic [31:0] v,
        input logic [31:0] h_visible
    );
        return v * h_visible + h;
    endfunction

endpackage

// File: rtl/vga2_fb_wrfifo.sv
// ---------------------------------------------------------------------------
// vga2_fb_wrfifo
// Small synchronous FIFO holding pending framebuffer writes.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, empties the queue
//   push   - write wdata at the tail (ignored when full)
//   pop    - drop the head entry (ignored when empty)
//   wdata  - entry to enqueue
//   rdata  - current head entry (valid while count != 0)
//   count  - number of stored entries
//   full   - count == Depth
// Depth must be a power of two and at least 2 so the pointers wrap freely.
// ---------------------------------------------------------------------------
module vga2_fb_wrfifo #(
    parameter int unsigned DataW = 22,
    parameter int unsigned Depth = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DataW-1:0]           wdata,
    output logic [DataW-1:0]           rdata,
    output logic [$clog2(Depth):0]     count,
    output logic                       full
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [DataW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CntW'(Depth));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vga2_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga2_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between a display
// fetcher (absolute priority) and a queued pixel writer.
// Ports:
//   clock, reset            - rising-edge clock, async active-low reset
//   disp_req/addr_h/addr_v  - display read request and coordinates
//   disp_color_r/g/b        - fetched pixel, valid 2 cycles after disp_req
//   wr_valid/wr_ready       - writer handshake, wr_addr_h/v and wr_color
//   wr_error                - 1-cycle pulse after an out-of-range write
//   ram_addr/we/wdata/rdata - RAM port, rdata valid one cycle after addr
//
// Writer handshake: a write transfers in any cycle where wr_valid and
// wr_ready are both 1. wr_ready depends only on queue fullness (and reset),
// never on wr_valid. The writer must hold its payload stable while
// wr_valid=1 and wr_ready=0. Out-of-range writes still transfer, but are
// dropped and reported on wr_error the following cycle.
// ---------------------------------------------------------------------------
module vga2_fb_arbiter
    import vga2_fb_arbiter_pkg::*;
#(
    parameter int unsigned HAddrSize    = DEF_H_ADDR_SIZE,
    parameter int unsigned VAddrSize    = DEF_V_ADDR_SIZE,
    parameter int unsigned HVisibleArea = DEF_H_VISIBLE,
    parameter int unsigned VVisibleArea = DEF_V_VISIBLE,
    parameter int unsigned RamAddrSize  = DEF_RAM_ADDR_SIZE,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   disp_req,
    input  logic [HAddrSize-1:0]   disp_addr_h,
    input  logic [VAddrSize-1:0]   disp_addr_v,
    output logic                   disp_color_r,
    output logic                   disp_color_g,
    output logic                   disp_color_b,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [HAddrSize-1:0]   wr_addr_h,
    input  logic [VAddrSize-1:0]   wr_addr_v,
    input  logic [2:0]             wr_color,
    output logic                   wr_error,
    output logic [RamAddrSize-1:0] ram_addr,
    output logic                   ram_we,
    output logic [2:0]             ram_wdata,
    input  logic [2:0]             ram_rdata
);

    localparam int unsigned EntryW = RamAddrSize + COLOR_W;

    logic [RamAddrSize-1:0]    disp_lin, wr_lin, head_addr;
    logic [COLOR_W-1:0]        head_color;
    logic [EntryW-1:0]         fifo_rdata;
    logic [$clog2(FifoDepth):0] fifo_count;
    logic                      fifo_full;
    logic                      in_range, accept, push, pop, serve_disp;

    logic [RamAddrSize-1:0]    addr_last_q;
    logic [COLOR_W-1:0]        wdata_last_q;
    logic                      rd_pend_q;
    logic [COLOR_W-1:0]        color_q, color_d;
    logic                      err_q;
    logic                      ready_en_q;

    assign disp_lin = RamAddrSize'(fb_addr(32'(disp_addr_h), 32'(disp_addr_v), HVisibleArea));
    assign wr_lin   = RamAddrSize'(fb_addr(32'(wr_addr_h), 32'(wr_addr_v), HVisibleArea));

    assign in_range = (32'(wr_addr_h) < HVisibleArea) && (32'(wr_addr_v) < VVisibleArea);
    assign wr_ready = ready_en_q && !fifo_full;
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && in_range;

    // Gating with reset forces ram_addr to 0 while reset is held, even if
    // the display keeps requesting.
    assign serve_disp = disp_req && reset;
    assign pop        = !serve_disp && (fifo_count != '0);

    assign head_addr  = fifo_rdata[EntryW-1:COLOR_W];
    assign head_color = fifo_rdata[COLOR_W-1:0];

    vga2_fb_wrfifo #(
        .DataW (EntryW),
        .Depth (FifoDepth)
    ) u_wrfifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({wr_lin, wr_color}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // RAM port: display first, then queue head; otherwise hold the last
    // address/data so the bus does not toggle on idle cycles.
    always_comb begin
        ram_addr  = addr_last_q;
        ram_wdata = wdata_last_q;
        if (serve_disp) begin
            ram_addr = disp_lin;
        end else if (pop) begin
            ram_addr  = head_addr;
            ram_wdata = head_color;
        end
    end
    assign ram_we = pop;

    assign color_d = rd_pend_q ? ram_rdata : color_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_last_q  <= '0;
            wdata_last_q <= '0;
            rd_pend_q    <= 1'b0;
            color_q      <= '0;
            err_q        <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            addr_last_q  <= ram_addr;
            wdata_last_q <= ram_wdata;
            rd_pend_q    <= serve_disp;
            color_q      <= color_d;
            err_q        <= accept && !in_range;
            ready_en_q   <= 1'b1;
        end
    end

    assign {disp_color_r, disp_color_g, disp_color_b} = color_q;
    assign wr_error = err_q;

endmodule
